// File: rtl/sw_capture_ctrl.sv
// sw_capture_ctrl: debounced, threshold-qualified capture of switch words into a
// small log, with timed replay of the log on the LEDs and the two hex digits.
// Optional feature macro: LOG_OVERWRITE_EN (when defined, a capture into a full
// log overwrites the oldest entry and replay starts from the oldest entry).
module sw_capture_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int THRESHOLD       = 20,
  parameter int DEPTH           = 4,
  parameter int SHOW_CYCLES     = 50000000
) (
  input  logic       clk50_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       mode_i,
  input  logic [9:0] sw_i,
  output logic [9:0] led_o,
  output logic [7:0] hex_val_o,
  output logic       full_o,
  output logic       play_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(SHOW_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [9:0]       SW_THRESH = 10'(THRESHOLD);

  // ---------------------------------------------------------------------------
  // Input conditioning: bit 0 is the push-button, bit 1 is the mode switch.
  // ---------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] db_lvl;

  assign raw_in = {mode_i, btn_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic            s1_q;
      logic            s2_q;
      logic            db_q;
      logic [DB_W-1:0] cnt_q;

      // Two-flop synchronizer, then flip the level only after a full run of disagreement.
      always_ff @(posedge clk50_i) begin
        if (rst_i) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q <= raw_in[gi];
          s2_q <= s1_q;
          if (s2_q == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            db_q  <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end
      end

      assign db_lvl[gi] = db_q;
    end
  endgenerate

  logic btn_prev_q;
  logic press_q;
  logic mode_db;

  assign mode_db = db_lvl[1];

  // Single-cycle press pulse on a debounced rising edge; release is ignored.
  always_ff @(posedge clk50_i) begin
    if (rst_i) begin
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      btn_prev_q <= db_lvl[0];
      press_q    <= db_lvl[0] & ~btn_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Record / replay state machine
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_REC, ST_PLAY} state_t;

  state_t             state_q,  state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [PTR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [TMR_W-1:0]   timer_q,  timer_d;
  logic [7:0]         acc_cnt_q, acc_cnt_d;
  logic [9:0]         last_q,   last_d;
  logic               log_we;
  logic [PTR_W-1:0]   rd_addr_d;
`ifdef LOG_OVERWRITE_EN
  logic [PTR_W-1:0]   oldest_q, oldest_d;
`endif

  logic [9:0] log_mem [DEPTH];
  logic [9:0] log_rd_q;

`ifdef LOG_OVERWRITE_EN
  // Replay index is logical (0 = oldest); map it onto the circular storage.
  assign rd_addr_d = oldest_d + rd_idx_d;
`else
  assign rd_addr_d = rd_idx_d;
`endif

  // Log storage: written from REC, read one cycle ahead of the displayed slot.
  always_ff @(posedge clk50_i) begin
    if (log_we) begin
      log_mem[wr_ptr_q] <= sw_i;
    end
    log_rd_q <= log_mem[rd_addr_d];
  end

  // State and bookkeeping registers; log contents are deliberately not reset.
  always_ff @(posedge clk50_i) begin
    if (rst_i) begin
      state_q   <= ST_REC;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_idx_q  <= '0;
      timer_q   <= '0;
      acc_cnt_q <= '0;
      last_q    <= '0;
`ifdef LOG_OVERWRITE_EN
      oldest_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_idx_q  <= rd_idx_d;
      timer_q   <= timer_d;
      acc_cnt_q <= acc_cnt_d;
      last_q    <= last_d;
`ifdef LOG_OVERWRITE_EN
      oldest_q  <= oldest_d;
`endif
    end
  end

  // Next-state logic; a mode change takes priority over a press in the same cycle.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rd_idx_d  = rd_idx_q;
    timer_d   = timer_q;
    acc_cnt_d = acc_cnt_q;
    last_d    = last_q;
    log_we    = 1'b0;
`ifdef LOG_OVERWRITE_EN
    oldest_d  = oldest_q;
`endif
    case (state_q)
      ST_REC: begin
        if (mode_db && (count_q != '0)) begin
          state_d  = ST_PLAY;
          rd_idx_d = '0;
          timer_d  = '0;
        end else if (press_q && (sw_i > SW_THRESH)) begin
          if (count_q < CNT_FULL) begin
            log_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            count_d   = count_q + CNT_W'(1);
            acc_cnt_d = acc_cnt_q + 8'd1;
            last_d    = sw_i;
          end
`ifdef LOG_OVERWRITE_EN
          else begin
            // Full log: the oldest entry sits at wr_ptr, so overwrite and slide both pointers.
            log_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            oldest_d  = oldest_q + PTR_W'(1);
            acc_cnt_d = acc_cnt_q + 8'd1;
            last_d    = sw_i;
          end
`endif
        end
      end
      ST_PLAY: begin
        if (!mode_db) begin
          state_d = ST_REC;
        end else if (press_q || (timer_q == TMR_LAST)) begin
          timer_d  = '0;
          rd_idx_d = ({1'b0, rd_idx_q} == (count_q - CNT_W'(1))) ? '0 : rd_idx_q + PTR_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_REC;
      end
    endcase
  end

  logic       in_play;
  logic [3:0] rd_idx_hex;

  // Output mux: REC shows last accepted word and accept count, PLAY shows the log.
  always_comb begin
    in_play    = (state_q == ST_PLAY);
    rd_idx_hex = 4'(rd_idx_q);
    play_o     = in_play;
    full_o     = (count_q == CNT_FULL);
    led_o      = last_q;
    hex_val_o  = acc_cnt_q;
    if (in_play) begin
      led_o     = log_rd_q;
      hex_val_o = {rd_idx_hex, log_rd_q[3:0]};
    end
  end

endmodule
